// File: rtl/host_stream_pkg.sv
// Shared types, register map and STATUS/CTRL bit positions for host_stream_sink.
package host_stream_pkg;

  typedef logic [31:0] uint32;
  typedef logic [63:0] uint64;

  localparam int DATALO = 0;
  localparam int DATAHI = 1;
  localparam int CTRL   = 2;
  localparam int STATUS = 3;

  localparam int LOPEND    = 0;
  localparam int ORPHAN    = 1;
  localparam int FULL      = 2;
  localparam int LEVEL_LSB = 16;

  localparam int CTRL_FLUSH = 0;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int ABITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pushValid,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic             o_empty,
  output logic             o_full,
  output logic [ABITS:0]   o_level
);

  localparam int DEPTH = 1 << ABITS;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ABITS:0]   r_wrPtr;
  logic [ABITS:0]   r_rdPtr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[ABITS] != r_rdPtr[ABITS]) &&
                   (r_wrPtr[ABITS-1:0] == r_rdPtr[ABITS-1:0]);
  assign w_pop   = i_pop && !w_empty;
  // A pop in the same cycle frees a slot, so a push is allowed even when full.
  assign w_push  = i_pushValid && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (ABITS+1)'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + (ABITS+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wrPtr[ABITS-1:0]] <= i_pushData;
  end

  assign o_headData = w_empty ? '0 : r_mem[r_rdPtr[ABITS-1:0]];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_level    = r_wrPtr - r_rdPtr;

endmodule

// File: rtl/host_stream_sink.sv
// MMIO-to-stream bridge: LO/HI register write pairs become 64-bit words in a
// show-ahead FIFO presented as a valid/ready stream.
module host_stream_sink
  import host_stream_pkg::*;
#(
  parameter int REG_ABITS  = 2,
  parameter int FIFO_ABITS = 4
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieResetN_in,
  input  logic [REG_ABITS-1:0] cpuChan_in,
  input  logic [31:0]          cpuWrData_in,
  input  logic                 cpuWrValid_in,
  output logic                 cpuWrReady_out,
  output logic [31:0]          cpuRdData_out,
  output logic                 cpuRdValid_out,
  input  logic                 cpuRdReady_in,
  output logic [63:0]          strmData_out,
  output logic                 strmValid_out,
  input  logic                 strmReady_in
);

  uint32             r_loReg;
  logic              r_loPending;
  logic              r_orphanHi;
  uint32             r_wordCount;

  logic              w_isLo;
  logic              w_isHi;
  logic              w_isCtrl;
  logic              w_isStat;
  logic              w_wrFire;
  logic              w_flush;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic [FIFO_ABITS:0] w_level;
  uint64             w_head;
  uint32             w_rdData;
  logic              w_unused;

  assign w_isLo   = (cpuChan_in == REG_ABITS'(DATALO));
  assign w_isHi   = (cpuChan_in == REG_ABITS'(DATAHI));
  assign w_isCtrl = (cpuChan_in == REG_ABITS'(CTRL));
  assign w_isStat = (cpuChan_in == REG_ABITS'(STATUS));

  // Only DATAHI can stall, and only on registered FIFO state.
  assign cpuWrReady_out = w_isHi ? !w_full : 1'b1;
  assign w_wrFire       = cpuWrValid_in && cpuWrReady_out;
  assign w_push         = w_wrFire && w_isHi;
  assign w_flush        = w_wrFire && w_isCtrl && cpuWrData_in[CTRL_FLUSH];

  sync_fifo #(
    .WIDTH (64),
    .ABITS (FIFO_ABITS)
  ) u_fifo (
    .i_clk       (pcieClk_in),
    .i_rstN      (pcieResetN_in),
    .i_flush     (w_flush),
    .i_pushData  ({cpuWrData_in, r_loReg}),
    .i_pushValid (w_push),
    .i_pop       (strmReady_in),
    .o_headData  (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_level     (w_level)
  );

  always_ff @(posedge pcieClk_in or negedge pcieResetN_in) begin
    if (!pcieResetN_in) begin
      r_loReg     <= '0;
      r_loPending <= 1'b0;
      r_orphanHi  <= 1'b0;
      r_wordCount <= '0;
    end else if (w_flush) begin
      r_loReg     <= '0;
      r_loPending <= 1'b0;
      r_orphanHi  <= 1'b0;
      r_wordCount <= '0;
    end else if (w_wrFire) begin
      if (w_isLo) begin
        r_loReg     <= cpuWrData_in;
        r_loPending <= 1'b1;
      end
      // A HI without a fresh LO still pushes the retained loReg but is flagged.
      if (w_isHi) begin
        r_loPending <= 1'b0;
        r_wordCount <= r_wordCount + 32'd1;
        if (!r_loPending) r_orphanHi <= 1'b1;
      end
      if (w_isStat && cpuWrData_in[ORPHAN]) r_orphanHi <= 1'b0;
    end
  end

  always_comb begin
    w_rdData = '0;
    if (w_isLo) begin
      w_rdData = r_loReg;
    end else if (w_isCtrl) begin
      w_rdData = r_wordCount;
    end else if (w_isStat) begin
      w_rdData[LOPEND]             = r_loPending;
      w_rdData[ORPHAN]             = r_orphanHi;
      w_rdData[FULL]               = w_full;
      w_rdData[LEVEL_LSB +: 16]    = 16'(w_level);
    end
  end

  assign cpuRdData_out  = w_rdData;
  assign cpuRdValid_out = 1'b1;
  assign strmData_out   = w_head;
  assign strmValid_out  = !w_empty;

  assign w_unused = cpuRdReady_in;

endmodule

// File: tb/tb_host_stream_sink.sv
// Randomised self-checking bench for host_stream_sink against a queue-based
// model of the register map and stream FIFO.
module tb_host_stream_sink;
  import host_stream_pkg::*;

  logic        pcieClk_in = 1'b0;
  logic        pcieResetN_in;
  logic [1:0]  cpuChan_in;
  logic [31:0] cpuWrData_in;
  logic        cpuWrValid_in;
  logic        cpuWrReady_out;
  logic [31:0] cpuRdData_out;
  logic        cpuRdValid_out;
  logic        cpuRdReady_in;
  logic [63:0] strmData_out;
  logic        strmValid_out;
  logic        strmReady_in;

  host_stream_sink #(.REG_ABITS(2), .FIFO_ABITS(4)) dut (
    .pcieClk_in     (pcieClk_in),
    .pcieResetN_in  (pcieResetN_in),
    .cpuChan_in     (cpuChan_in),
    .cpuWrData_in   (cpuWrData_in),
    .cpuWrValid_in  (cpuWrValid_in),
    .cpuWrReady_out (cpuWrReady_out),
    .cpuRdData_out  (cpuRdData_out),
    .cpuRdValid_out (cpuRdValid_out),
    .cpuRdReady_in  (cpuRdReady_in),
    .strmData_out   (strmData_out),
    .strmValid_out  (strmValid_out),
    .strmReady_in   (strmReady_in)
  );

  always #4 pcieClk_in = ~pcieClk_in;

  // Reference model: FIFO contents as a queue plus the register state.
  uint64 modelQ[$];
  uint32 modelLo;
  uint32 modelWc;
  bit    modelLoPend;
  bit    modelOrphan;

  int compared;
  int mismatched;

  uint32       lastRd;
  logic        lastReady;
  logic        lastValid;
  logic [63:0] lastData;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic uint32 modelRead(input int chan);
    int lvl;
    lvl = modelQ.size();
    case (chan)
      0:       return modelLo;
      2:       return modelWc;
      3:       return 32'(lvl * 65536 + ((lvl == 16) ? 4 : 0) +
                          (modelOrphan ? 2 : 0) + (modelLoPend ? 1 : 0));
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelClear();
    modelQ.delete();
    modelLo     = 0;
    modelWc     = 0;
    modelLoPend = 0;
    modelOrphan = 0;
  endtask

  // Drive one cycle, check every combinational output against the model,
  // then advance the model across the clock edge.
  task automatic applyStimulus(input int chan, input uint32 data,
                               input bit wrValid, input bit rdy);
    bit expReady, fire, flush, pop;
    cpuChan_in    = 2'(chan);
    cpuWrData_in  = data;
    cpuWrValid_in = wrValid;
    strmReady_in  = rdy;
    cpuRdReady_in = 1'($urandom_range(0, 1));
    #1;
    expReady = (chan != 1) || (modelQ.size() < 16);
    checkOutput("wrReady", 64'(cpuWrReady_out), 64'(expReady));
    checkOutput("rdData", 64'(cpuRdData_out), 64'(modelRead(chan)));
    checkOutput("rdValid", 64'(cpuRdValid_out), 64'd1);
    checkOutput("strmValid", 64'(strmValid_out), 64'(modelQ.size() != 0));
    checkOutput("strmData", strmData_out, (modelQ.size() != 0) ? modelQ[0] : 64'd0);
    lastRd    = cpuRdData_out;
    lastReady = cpuWrReady_out;
    lastValid = strmValid_out;
    lastData  = strmData_out;
    fire  = wrValid && expReady;
    flush = fire && (chan == 2) && data[0];
    pop   = rdy && (modelQ.size() != 0) && !flush;
    @(posedge pcieClk_in);
    if (flush) begin
      modelClear();
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (fire) begin
        case (chan)
          0: begin modelLo = data; modelLoPend = 1; end
          1: begin
            modelQ.push_back({data, modelLo});
            if (!modelLoPend) modelOrphan = 1;
            modelLoPend = 0;
            modelWc     = modelWc + 1;
          end
          3: if (data[1]) modelOrphan = 0;
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic writePairs(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, $urandom, 1, rdy);
      applyStimulus(1, $urandom, 1, rdy);
    end
  endtask

  task automatic flushAll();
    applyStimulus(2, 32'h1, 1, 0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    modelClear();
    pcieResetN_in = 1'b0;
    cpuChan_in    = '0;
    cpuWrData_in  = '0;
    cpuWrValid_in = 1'b0;
    cpuRdReady_in = 1'b0;
    strmReady_in  = 1'b0;
    repeat (2) @(posedge pcieClk_in);
    @(negedge pcieClk_in);
    pcieResetN_in = 1'b1;
    @(posedge pcieClk_in);
    #1;

    // Reset state
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_wrReady", 64'(lastReady), 64'd1);
    checkOutput("rst_strmValid", 64'(lastValid), 64'd0);
    checkOutput("rst_strmData", lastData, 64'd0);
    applyStimulus(3, 0, 0, 0);
    checkOutput("rst_status", 64'(lastRd), 64'd0);

    // First word and its one-cycle latency
    applyStimulus(0, 32'h11223344, 1, 0);
    applyStimulus(1, 32'hAABBCCDD, 1, 0);
    applyStimulus(2, 0, 0, 0);
    checkOutput("first_valid", 64'(lastValid), 64'd1);
    checkOutput("first_data", lastData, 64'hAABBCCDD11223344);
    checkOutput("first_count", 64'(lastRd), 64'd1);
    applyStimulus(3, 0, 0, 0);
    checkOutput("first_status", 64'(lastRd), 64'h00010000);

    // Fill to full, then a stalled 17th HI released by one pop
    flushAll();
    writePairs(16, 0);
    applyStimulus(3, 0, 0, 0);
    checkOutput("full_status", 64'(lastRd), 64'h00100004);
    applyStimulus(0, 32'hCAFE0017, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hBEEF0017, 1, 0);
      checkOutput("stall_ready", 64'(lastReady), 64'd0);
    end
    applyStimulus(1, 32'hBEEF0017, 1, 1);
    checkOutput("stall_pop_ready", 64'(lastReady), 64'd0);
    applyStimulus(1, 32'hBEEF0017, 1, 0);
    checkOutput("release_ready", 64'(lastReady), 64'd1);
    applyStimulus(3, 0, 0, 0);
    checkOutput("release_status", 64'(lastRd), 64'h00100004);

    // Orphan HI after flush and write-one-to-clear
    flushAll();
    applyStimulus(1, 32'h5, 1, 0);
    applyStimulus(3, 0, 0, 0);
    checkOutput("orphan_data", lastData, 64'h0000000500000000);
    checkOutput("orphan_status", 64'(lastRd), 64'h00010002);
    applyStimulus(3, 32'h2, 1, 0);
    applyStimulus(3, 0, 0, 0);
    checkOutput("orphan_clear", 64'(lastRd), 64'h00010000);

    // Flush wins over a simultaneous consume
    flushAll();
    writePairs(3, 0);
    applyStimulus(2, 32'h1, 1, 1);
    applyStimulus(2, 0, 0, 0);
    checkOutput("flush_valid", 64'(lastValid), 64'd0);
    checkOutput("flush_count", 64'(lastRd), 64'd0);
    applyStimulus(3, 0, 0, 0);
    checkOutput("flush_status", 64'(lastRd), 64'd0);

    // Randomised traffic on all channels
    flushAll();
    for (int i = 0; i < 400; i++) begin
      int    ch;
      uint32 d;
      ch = int'($urandom_range(0, 3));
      d  = $urandom;
      if (ch == 2) d[0] = ($urandom_range(0, 9) == 0);
      applyStimulus(ch, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Continuous stream of 1000 words
    flushAll();
    writePairs(1000, 1);
    applyStimulus(2, 0, 0, 1);
    checkOutput("stream_count", 64'(lastRd), 64'd1000);

    // Asynchronous reset with words buffered
    flushAll();
    writePairs(5, 0);
    applyStimulus(3, 0, 0, 0);
    checkOutput("pre_reset_status", 64'(lastRd), 64'h00050000);
    #1;
    pcieResetN_in = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(strmValid_out), 64'd0);
    modelClear();
    @(negedge pcieClk_in);
    pcieResetN_in = 1'b1;
    @(posedge pcieClk_in);
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      applyStimulus(ch, 0, 0, 0);
      checkOutput("post_reset_reg", 64'(lastRd), 64'd0);
    end
    checkOutput("post_reset_valid", 64'(lastValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/host_stream_sink.md
Name: host_stream_sink

Overview:
- Register-mapped responder on the tlp_xcvr internal read/write interface.
- Turns CPU MMIO writes into a 64-bit valid/ready stream toward FPGA logic. This is the host-to-FPGA counterpart of the FPGA-to-host DMA stream.
- Two 32-bit writes (LO, then HI) form one 64-bit word, which is pushed into a show-ahead FIFO.
- Status and counter registers are readable by the CPU.

Parameters:
- REG_ABITS, 2: register address width; 4 registers used.
- FIFO_ABITS, 4: FIFO depth = 2**FIFO_ABITS words (16).

Ports:
- pcieClk_in  in  1  125MHz PCIe clock; the only clock.
- pcieResetN_in  in  1  reset, asynchronous, active-low.
- cpuChan_in  in  REG_ABITS  register address for the current read/write.
- cpuWrData_in  in  32  CPU write data.
- cpuWrValid_in  in  1  CPU write request.
- cpuWrReady_out  out  1  write accepted when high with cpuWrValid_in.
- cpuRdData_out  out  32  read data for cpuChan_in.
- cpuRdValid_out  out  1  read data valid.
- cpuRdReady_in  in  1  CPU consuming read data this cycle.
- strmData_out  out  64  stream word (FIFO head).
- strmValid_out  out  1  FIFO non-empty.
- strmReady_in  in  1  consumer accepts head word.

Behaviour:
- Register map:
  - 0 DATALO
  - 1 DATAHI
  - 2 CTRL
  - 3 STATUS
- Write handshake: a write fires when cpuWrValid_in && cpuWrReady_out.
- cpuWrReady_out = 1 for chans 0, 2, 3; for chan 1 it equals !full. It is combinational from cpuChan_in and registered FIFO state only, never from strmReady_in.
- DATALO write: loReg <= cpuWrData_in; loPending <= 1. A repeated LO write overwrites loReg.
- DATAHI write: push {cpuWrData_in, loReg} into the FIFO (HI in bits 63:32); loPending <= 0; wordCount <= wordCount + 1.
  - A HI write without a pending LO still pushes, using the retained loReg.
  - It also sets the orphanHi sticky flag.
- CTRL write:
  - bit0 = 1 flushes: FIFO emptied, loPending, orphanHi and wordCount cleared, loReg = 0.
  - bit0 = 0 has no effect.
  - Other bits are ignored.
- STATUS write: write-one-to-clear orphanHi via bit1; other bits ignored.
- Reads:
  - cpuRdValid_out is constant 1.
  - cpuRdData_out is a combinational mux on cpuChan_in.
  - cpuRdReady_in has no side effects (no read-to-clear).
- Read values:
  - chan0 returns loReg.
  - chan1 returns 0.
  - chan2 returns wordCount (32-bit, wraps 0xFFFFFFFF to 0).
  - chan3 returns {level[15:0], 13'b0, full, orphanHi, loPending}; level is zero-extended from FIFO_ABITS+1 bits.
- FIFO behaviour:
  - Show-ahead: strmData_out is the head word. strmValid_out = !empty.
  - A pop occurs on strmValid_out && strmReady_in.
  - Latency from the accepted DATAHI write to strmValid_out is 1 cycle: the word is visible the cycle after the write edge.
  - Simultaneous push and pop: both occur, level unchanged; allowed even when full.
  - Simultaneous push and pop on an empty FIFO: no pop, since strmValid_out is low; the push lands.
- Flush priority: a flush in the same cycle as a pop or a stream consume wins. Level becomes 0 and nothing pops.
- Reset (async assert, sync-safe deassert is the top level's job):
  - FIFO empty, loReg = 0, loPending = 0, orphanHi = 0, wordCount = 0.
  - Outputs: strmValid_out = 0, strmData_out = 0 at reset (FIFO RAM contents don't-care, but the head output is muxed to 0 when empty), cpuWrReady_out = 1 (not full).
  - Reset mid-stream discards all buffered words without a partial handshake.
- Level width is FIFO_ABITS+1; read/write pointers are FIFO_ABITS+1 bits, using the MSB to distinguish full from empty.

Decomposition:
- Package host_stream_pkg holds:
  - typedefs uint32 and uint64;
  - localparams DATALO = 0, DATAHI = 1, CTRL = 2, STATUS = 3;
  - STATUS bit positions: LOPEND = 0, ORPHAN = 1, FULL = 2, LEVEL_LSB = 16;
  - CTRL_FLUSH = 0.
- One sub-module, sync_fifo.
  - Parameters: WIDTH, ABITS.
  - Ports: clock, async active-low reset, synchronous flush, push data/valid, pop, head data, empty, full, level.
- The register decode, the loPending/orphanHi state and wordCount stay in host_stream_sink.

Test Plan:
- Reset, then write chan0 = 0x11223344 and chan1 = 0xAABBCCDD, strmReady_in = 0.
  - strmValid_out = 1 one cycle later, strmData_out = 0xAABBCCDD11223344.
  - Read chan2 = 1; read chan3 = 0x00010000.
- Push 16 LO/HI pairs with strmReady_in = 0.
  - STATUS = 0x00100004 (full).
  - A 17th HI write sees cpuWrReady_out = 0 until strmReady_in pulses for one cycle; then it is accepted and level stays 16.
- Write chan1 = 0x5 with no preceding LO after a flush.
  - Pushed word = 0x0000000500000000; STATUS bit1 = 1.
  - Writing STATUS = 0x2 clears it.
- Fill 3 words, then write CTRL = 0x1 in the same cycle that strmReady_in = 1.
  - Next cycle: strmValid_out = 0, level = 0, wordCount = 0, and no pop was observed by the consumer.
- Continuous stream: alternate LO/HI writes every cycle with strmReady_in = 1.
  - Words emerge in order with no loss or duplication over 1000 words; wordCount = 1000.
- Pulse pcieResetN_in low mid-stream with 5 words buffered.
  - strmValid_out drops immediately (asynchronously); all registers read 0 after release.
